// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers for the fifo block. Provides the pointer-width
//                calculation used by the top level and by the storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Address width for a given number of entries. The minimum is one bit, so
   // a single-entry FIFO still has a legal pointer.
   function automatic int ptr_width(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_array.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_array
//  Description : depth x width register file that stores FIFO entries.
//                It has one synchronous write port and one asynchronous
//                read-address port. The array has no reset, so its contents
//                are undefined until they are written.
//  Ports       : clk   - clock; a write is performed on the rising edge
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data (combinational from raddr)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_array
   import fifo_pkg::*;
#(
   parameter int depth = 16,
   parameter int width = 8,
   parameter int aw    = ptr_width(depth)
)
(
   input  logic             clk,
   input  logic             we,
   input  logic [aw-1:0]    waddr,
   input  logic [width-1:0] wdata,
   input  logic [aw-1:0]    raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo
//  Description : Synchronous single-clock FIFO of depth entries of width bits.
//                depth can be any integer >= 1. Pointers wrap by explicit
//                compare against depth-1.
//  Ports       : clk       - clock; all state changes on the rising edge
//                rst       - asynchronous active-low reset
//                wr        - write strobe
//                rd        - read strobe
//                data_in   - write data, sampled with wr
//                data_out  - registered read data; it holds until the next
//                            accepted read
//                full      - occupancy equals depth
//                empty     - occupancy equals zero
//                overflow  - one cycle after a refused write
//                underflow - one cycle after a refused read
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo
   import fifo_pkg::*;
#(
   parameter int depth = 16,
   parameter int width = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             rd,
   input  logic [width-1:0] data_in,
   output logic [width-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int            aw        = ptr_width(depth);
   localparam int            cw        = $clog2(depth + 1);
   localparam logic [aw-1:0] last_ptr  = aw'(depth - 1);
   localparam logic [cw-1:0] max_count = cw'(depth);

   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [cw-1:0]    count;
   logic [width-1:0] rd_word;
   logic             rd_ok;
   logic             wr_ok;

   assign full  = (count == max_count);
   assign empty = (count == '0);

   // A read is refused when the FIFO is empty, so a write on an empty FIFO
   // never passes straight through. A write on a full FIFO is accepted only
   // when a read frees a slot on the same edge.
   assign rd_ok = rd && !empty;
   assign wr_ok = wr && (!full || rd_ok);

   fifo_array #(
      .depth (depth),
      .width (width),
      .aw    (aw)
   ) u_array (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr   <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            data_out <= rd_word;
         end
         if (wr_ok && !rd_ok) begin
            count <= count + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            count <= count - 1'b1;
         end
         overflow  <= wr && !wr_ok;
         underflow <= rd && !rd_ok;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo
//  Description : Self-checking bench for fifo. It uses two instances: a
//                29-entry FIFO and a 5-entry FIFO. A reference queue per
//                instance models the contents. Each accepted read pushes its
//                expected word onto a scoreboard. That word is popped and
//                compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_a = 1'b0, rd_a = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
   logic [7:0] din_a = '0, din_b = '0;
   logic [7:0] dout_a, dout_b;
   logic       full_a, empty_a, ovf_a, unf_a;
   logic       full_b, empty_b, ovf_b, unf_b;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] model_a[$];
   logic [7:0] model_b[$];
   logic [7:0] sb_a[$];
   logic [7:0] sb_b[$];
   logic [7:0] last_a = '0;
   logic [7:0] last_b = '0;

   always #5 clk = ~clk;

   fifo #(.depth(29), .width(8)) dut_a (
      .clk(clk), .rst(rst), .wr(wr_a), .rd(rd_a), .data_in(din_a),
      .data_out(dout_a), .full(full_a), .empty(empty_a),
      .overflow(ovf_a), .underflow(unf_a)
   );

   fifo #(.depth(5), .width(8)) dut_b (
      .clk(clk), .rst(rst), .wr(wr_b), .rd(rd_b), .data_in(din_b),
      .data_out(dout_b), .full(full_b), .empty(empty_b),
      .overflow(ovf_b), .underflow(unf_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle on instance sel (0 = depth 29, 1 = depth 5).
   task automatic cycle(input int sel, input bit w, input bit r, input logic [7:0] d);
      int         dep;
      int         cnt;
      bit         rd_ok;
      bit         wr_ok;
      logic [7:0] e;
      @(negedge clk);
      dep   = (sel == 0) ? 29 : 5;
      cnt   = (sel == 0) ? model_a.size() : model_b.size();
      rd_ok = r && (cnt != 0);
      wr_ok = w && ((cnt != dep) || rd_ok);
      if (sel == 0) begin
         wr_a = w; rd_a = r; din_a = d;
         if (rd_ok) sb_a.push_back(model_a.pop_front());
         if (wr_ok) model_a.push_back(d);
      end else begin
         wr_b = w; rd_b = r; din_b = d;
         if (rd_ok) sb_b.push_back(model_b.pop_front());
         if (wr_ok) model_b.push_back(d);
      end
      @(posedge clk);
      #1;
      wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
      if (sel == 0) begin
         if (rd_ok) begin
            e = sb_a.pop_front();
            last_a = e;
            chk("a_read_data", dout_a, e);
         end else begin
            chk("a_data_hold", dout_a, last_a);
         end
         chk("a_overflow", ovf_a, w && !wr_ok);
         chk("a_underflow", unf_a, r && !rd_ok);
         chk("a_full", full_a, model_a.size() == 29);
         chk("a_empty", empty_a, model_a.size() == 0);
      end else begin
         if (rd_ok) begin
            e = sb_b.pop_front();
            last_b = e;
            chk("b_read_data", dout_b, e);
         end else begin
            chk("b_data_hold", dout_b, last_b);
         end
         chk("b_overflow", ovf_b, w && !wr_ok);
         chk("b_underflow", unf_b, r && !rd_ok);
         chk("b_full", full_b, model_b.size() == 5);
         chk("b_empty", empty_b, model_b.size() == 0);
      end
   endtask

   // Assert the reset between clock edges, check that it takes effect
   // immediately, then release it away from any edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_a_empty", empty_a, 1'b1);
      chk("rst_a_full", full_a, 1'b0);
      chk("rst_a_ovf", ovf_a, 1'b0);
      chk("rst_a_unf", unf_a, 1'b0);
      chk("rst_a_dout", dout_a, 8'h00);
      chk("rst_b_empty", empty_b, 1'b1);
      chk("rst_b_dout", dout_b, 8'h00);
      model_a.delete(); model_b.delete();
      sb_a.delete();    sb_b.delete();
      last_a = '0;      last_b = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      do_reset();

      // Fill the depth-29 instance, then write once more into the full FIFO.
      for (int i = 0; i < 29; i++) cycle(0, 1'b1, 1'b0, 8'(i));
      cycle(0, 1'b1, 1'b0, 8'd29);
      cycle(0, 1'b0, 1'b0, 8'd0);          // overflow is not sticky
      for (int i = 0; i < 20; i++) cycle(0, 1'b0, 1'b1, 8'd0);
      for (int i = 0; i < 9; i++)  cycle(0, 1'b0, 1'b1, 8'd0);
      cycle(0, 1'b0, 1'b1, 8'd0);          // underflow, data_out holds 28
      cycle(0, 1'b0, 1'b0, 8'd0);
      cycle(0, 1'b1, 1'b1, 8'h5A);         // empty: write stored, read refused
      cycle(0, 1'b0, 1'b1, 8'd0);          // read back 5A

      // Simultaneous read and write while full.
      for (int i = 0; i < 29; i++) cycle(0, 1'b1, 1'b0, 8'(100 + i));
      cycle(0, 1'b1, 1'b1, 8'hEE);
      cycle(0, 1'b1, 1'b1, 8'hEF);

      // Wrap on the depth-5 instance: write 5, read 3, write 3, drain.
      for (int i = 0; i < 5; i++) cycle(1, 1'b1, 1'b0, 8'(10 + i));
      cycle(1, 1'b1, 1'b0, 8'hFF);
      for (int i = 0; i < 3; i++) cycle(1, 1'b0, 1'b1, 8'd0);
      for (int i = 0; i < 3; i++) cycle(1, 1'b1, 1'b0, 8'(20 + i));
      for (int i = 0; i < 6; i++) cycle(1, 1'b0, 1'b1, 8'd0);

      // Random traffic on the depth-5 instance.
      for (int i = 0; i < 300; i++)
         cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

      // Reset while both instances hold data. Old data must never come back.
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0, 8'(200 + i));
      for (int i = 0; i < 3; i++) cycle(1, 1'b1, 1'b0, 8'(210 + i));
      do_reset();
      cycle(0, 1'b0, 1'b1, 8'd0);          // empty after reset: underflow
      cycle(1, 1'b0, 1'b1, 8'd0);
      cycle(0, 1'b1, 1'b0, 8'h77);
      cycle(0, 1'b0, 1'b1, 8'd0);          // returns 77, not 200
      cycle(1, 1'b1, 1'b1, 8'h66);
      cycle(1, 1'b0, 1'b1, 8'd0);          // returns 66, not 210

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
